// File: rtl/fifo.sv
// -----------------------------------------------------------------------------
// fifo
//
// Circular-buffer FIFO clocked on the falling edge of clk. push and pop are
// edge-detected against their previous samples, so each low-to-high pulse
// performs exactly one operation regardless of how long it is held high.
//
// Parameters
//   FIFO_SIZE   number of stored words (>= 2, need not be a power of two)
//   DATA_WIDTH  word width in bits
//
// Ports
//   clk          single clock, all state updates on its falling edge
//   clear        asynchronous active-high reset
//   push         write request (one write per rising transition)
//   pop          read request (one read per rising transition)
//   in_data      word captured on a write
//   out_data     most recently popped word, registered
//   popped_last  high while the FIFO is empty, registered
//   pushed_last  high while the FIFO is full, registered
// -----------------------------------------------------------------------------
module fifo #(
  parameter int FIFO_SIZE  = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  popped_last,
  output logic                  pushed_last
);

  localparam int PTR_W = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1;
  localparam int CNT_W = $clog2(FIFO_SIZE + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_SIZE);

  // Explicit wrap so non-power-of-two depths never index past the buffer.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_LAST) begin
      return '0;
    end
    return ptr + PTR_W'(1);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [FIFO_SIZE];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_SIZE];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  push_prev_q, push_prev_d;
  logic                  pop_prev_q, pop_prev_d;

  logic push_act;
  logic pop_act;
  logic do_push;
  logic do_pop;

  always_comb begin
    push_act = push & ~push_prev_q;
    pop_act  = pop & ~pop_prev_q;
    // A pop needs data; a push needs room, or a pop on the same edge freeing
    // a slot. On an empty FIFO a simultaneous pop is dropped and the push alone
    // proceeds.
    do_pop   = pop_act && (count_q != '0);
    do_push  = push_act && ((count_q != CNT_FULL) || do_pop);
  end

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    push_prev_d = push;
    pop_prev_d  = pop;

    if (do_push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end

    // The read slot is taken from mem_q, so a full-FIFO push+pop returns the
    // oldest word even though the write targets the same physical slot.
    if (do_pop) begin
      out_data_d = mem_q[rd_ptr_q];
      rd_ptr_d   = next_ptr(rd_ptr_q);
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Flags follow the post-operation count from the same edge.
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_FULL);
  end

  always_ff @(negedge clk or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < FIFO_SIZE; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      push_prev_q <= 1'b0;
      pop_prev_q  <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      push_prev_q <= push_prev_d;
      pop_prev_q  <= pop_prev_d;
    end
  end

  assign out_data    = out_data_q;
  assign popped_last = empty_q;
  assign pushed_last = full_q;

endmodule

// File: tb/tb_fifo.sv
// -----------------------------------------------------------------------------
// tb_fifo
//
// Self-checking bench for fifo (FIFO_SIZE=3, DATA_WIDTH=8). A queue-based
// reference model tracks contents, the last popped word and the flags; directed
// scenarios are followed by randomized push/pop pulses of random length and
// occasional asynchronous clears.
// -----------------------------------------------------------------------------
module tb_fifo;

  localparam int SIZE = 3;
  localparam int DW   = 8;

  logic          clk;
  logic          clear;
  logic          push;
  logic          pop;
  logic [DW-1:0] in_data;
  logic [DW-1:0] out_data;
  logic          popped_last;
  logic          pushed_last;

  int checks;
  int failures;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] model_out;

  fifo #(
    .FIFO_SIZE (SIZE),
    .DATA_WIDTH(DW)
  ) dut (
    .clk        (clk),
    .clear      (clear),
    .push       (push),
    .pop        (pop),
    .in_data    (in_data),
    .out_data   (out_data),
    .popped_last(popped_last),
    .pushed_last(pushed_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".out"},   32'(out_data),    32'(model_out));
    check({tag, ".empty"}, 32'(popped_last), 32'(model_q.size() == 0));
    check({tag, ".full"},  32'(pushed_last), 32'(model_q.size() == SIZE));
  endtask

  // Reference behaviour of one edge-detected operation.
  task automatic model_op(input bit ps, input bit pp, input logic [DW-1:0] d);
    bit pop_ok;
    bit push_ok;
    pop_ok  = pp && (model_q.size() > 0);
    push_ok = ps && ((model_q.size() < SIZE) || pop_ok);
    if (pop_ok) model_out = model_q.pop_front();
    if (push_ok) model_q.push_back(d);
  endtask

  // Raise the requested lines for 'hold' falling edges, drop them, then check
  // half a clock after the operating edge.
  task automatic do_op(input string tag, input bit ps, input bit pp,
                       input logic [DW-1:0] d, input int hold);
    @(posedge clk);
    push    = ps;
    pop     = pp;
    in_data = d;
    repeat (hold) @(negedge clk);
    @(posedge clk);
    push = 1'b0;
    pop  = 1'b0;
    model_op(ps, pp, d);
    check_state(tag);
  endtask

  // Clear asserted between clock edges; its effect must be visible at once.
  task automatic do_clear(input string tag);
    @(posedge clk);
    push = 1'b0;
    pop  = 1'b0;
    #2 clear = 1'b1;
    #1;
    model_q.delete();
    model_out = '0;
    check_state(tag);
    @(posedge clk);
    clear = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    clear     = 1'b1;
    push      = 1'b0;
    pop       = 1'b0;
    in_data   = '0;
    model_out = '0;

    // Reset state.
    #1;
    check_state("reset");
    repeat (2) @(posedge clk);
    clear = 1'b0;

    // Basic push/pop ordering.
    do_op("push_ac", 1, 0, 8'hAC, 1);
    do_op("push_61", 1, 0, 8'h61, 1);
    do_op("pop1",    0, 1, 8'h00, 1);
    do_op("pop2",    0, 1, 8'h00, 1);

    // Fill through a write-pointer wrap, overflow attempt, drain.
    do_op("push_11", 1, 0, 8'h11, 1);
    do_op("push_39", 1, 0, 8'h39, 1);
    do_op("push_7d", 1, 0, 8'h7D, 1);
    do_op("push_ff_full", 1, 0, 8'hFF, 1);
    do_op("pop_11", 0, 1, 8'h00, 1);
    do_op("pop_39", 0, 1, 8'h00, 1);
    do_op("pop_7d", 0, 1, 8'h00, 1);

    // Pop when empty, then a long push pulse stores a single word.
    do_op("pop_empty", 0, 1, 8'h00, 1);
    do_op("push_long", 1, 0, 8'h5C, 5);
    do_op("pop_long",  0, 1, 8'h00, 1);
    do_op("pop_long_empty", 0, 1, 8'h00, 1);

    // Simultaneous push/pop: on empty only the push happens; on full both do.
    do_op("both_empty", 1, 1, 8'h44, 1);
    do_op("push_a1", 1, 0, 8'hA1, 1);
    do_op("push_a2", 1, 0, 8'hA2, 1);
    do_op("both_full", 1, 1, 8'h22, 2);
    do_op("drain1", 0, 1, 8'h00, 1);
    do_op("drain2", 0, 1, 8'h00, 1);
    do_op("drain3", 0, 1, 8'h00, 1);

    // Mid-sequence clear discards contents.
    do_op("pre_clr1", 1, 0, 8'h9E, 1);
    do_op("pre_clr2", 1, 0, 8'h3B, 1);
    do_clear("mid_clear");
    do_op("post_clr_pop", 0, 1, 8'h00, 1);

    // push held during clear: no effect while clear is high, and counts as a
    // fresh rising edge on the first falling edge after release.
    @(posedge clk);
    clear   = 1'b1;
    push    = 1'b1;
    in_data = 8'h5A;
    @(negedge clk);
    @(posedge clk);
    model_q.delete();
    model_out = '0;
    check_state("push_in_clear");
    clear = 1'b0;
    @(negedge clk);
    @(posedge clk);
    push = 1'b0;
    model_op(1, 0, 8'h5A);
    check_state("push_after_clear");
    do_op("pop_5a", 0, 1, 8'h00, 1);

    // Randomized traffic with pulses of varying length and rare clears.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        do_clear("rnd_clear");
      end else begin
        bit ps;
        bit pp;
        ps = (r < 55);
        pp = (r >= 40);
        do_op("rnd", ps, pp, 8'($urandom), int'($urandom_range(1, 3)));
      end
    end

    // Drain what is left and confirm FIFO order.
    for (int i = 0; i < SIZE + 1; i++) begin
      do_op("final_drain", 0, 1, 8'h00, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 Parameter FIFO_SIZE, default 8: number of stored words, any integer >= 2; non-power-of-two sizes are legal.
REQ-002 Parameter DATA_WIDTH, default 8: word width in bits.
REQ-003 clk  input  1: the single clock; all synchronous state updates on its falling edge.
REQ-004 clear  input  1: asynchronous, active-high reset.
REQ-005 push  input  1: write request; one write per low-to-high transition.
REQ-006 pop  input  1: read request; one read per low-to-high transition.
REQ-007 in_data  input  DATA_WIDTH: word captured on a write.
REQ-008 out_data  output  DATA_WIDTH: most recently popped word, registered.
REQ-009 popped_last  output  1: high when the FIFO is empty (count == 0), registered.
REQ-010 pushed_last  output  1: high when the FIFO is full (count == FIFO_SIZE), registered.

Function
REQ-011 The FIFO SHALL keep a circular buffer of FIFO_SIZE words with write pointer, read pointer and count (0..FIFO_SIZE).
- Pointers wrap explicitly from FIFO_SIZE-1 to 0, with no reliance on power-of-two overflow.
REQ-012 push and pop SHALL be sampled on each falling clk edge into previous-value registers.
- A request is active only on the sample where it is 1 and its previous sample was 0.
- This gives one operation per pulse, for any pulse length of at least one half clock period.
REQ-013 Active push with count < FIFO_SIZE: on the same falling edge, in_data is written at the write pointer, the write pointer advances, and count increments.
REQ-014 Active push while full SHALL be ignored, unless an active pop occurs on the same edge.
REQ-015 Active pop with count > 0: on the same falling edge, out_data loads the word at the read pointer, the read pointer advances, and count decrements.
REQ-016 Active pop while empty SHALL be ignored, and out_data keeps its value.
REQ-017 Simultaneous active push and pop:
- Non-empty FIFO: both operations execute and count is unchanged, including when full.
- Empty FIFO: only the push executes.
REQ-018 out_data SHALL hold its value between pops and never changes on a push.
REQ-019 popped_last and pushed_last SHALL reflect the post-operation count from the same falling edge that changes it, i.e. a one-half-clock latency after the request is sampled.
REQ-020 Order SHALL be strictly first-in first-out across any number of pointer wraps.

Reset
REQ-021 clear = 1 SHALL, immediately and independent of clk, set:
- pointers = 0, count = 0;
- all storage words = 0, out_data = 0;
- popped_last = 1, pushed_last = 0;
- push/pop previous-value registers = 0.
REQ-022 While clear is high, push and pop SHALL have no effect.
REQ-023 Asserting clear mid-operation SHALL discard all contents.
REQ-024 Operation SHALL resume on the first falling edge after clear deasserts.
- A push or pop already high at that edge counts as a new rising transition.

Verification (FIFO_SIZE=3, DATA_WIDTH=8)
REQ-025 Pulse clear -> out_data = 0x00, popped_last = 1, pushed_last = 0.
REQ-026 Push 0xAC, push 0x61 -> pushed_last = 0, popped_last = 0.
REQ-027 Then pop -> out_data = 0xAC, popped_last = 0.
- Then pop again -> out_data = 0x61, popped_last = 1.
REQ-028 Push 0x11, 0x39, 0x7D (write pointer wraps) -> pushed_last = 1.
- A fourth push of 0xFF is ignored.
- Then pop -> out_data = 0x11, pushed_last = 0.
- Remaining pops -> 0x39, 0x7D, popped_last = 1.
REQ-029 Pop when empty -> out_data unchanged, flags unchanged.
- push held high for 5 clocks -> exactly one word stored.
REQ-030 Simultaneous push 0x22 and pop when full -> out_data = oldest word, pushed_last stays 1.
- Assert clear mid-sequence -> empty and flags reset at once, asynchronously.
